// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce scheduler: FSM state encoding,
// default timing constants and the index-width helper.
package debounce_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEFAULT_STABLE_CYCLES = 500000;
  localparam int DEFAULT_CNT_WIDTH     = 20;

  // Bits needed to hold an index 0..n-1 (at least 1).
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Ports:
//   req        - request vector, one bit per channel
//   last_grant - index of the most recent grant
//   pick       - first requesting index after last_grant (with wrap)
//   valid      - high when any request is present
module rr_arbiter
  import debounce_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [clog2(N)-1:0]  last_grant,
  output logic [clog2(N)-1:0]  pick,
  output logic                 valid
);

  localparam int IW = clog2(N);

  int idx;

  // Scan from farthest to nearest so the nearest requester after
  // last_grant is the final assignment and therefore wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N;
      if (req[idx[IW-1:0]]) begin
        pick  = idx[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces N_CH raw inputs using a single shared
// stability timer handed out round-robin to channels whose synchronised
// level differs from their committed output.
// Ports:
//   clk         - system clock, rising edge
//   async_reset - asynchronous, active-high reset
//   in          - raw asynchronous inputs
//   out         - debounced committed levels
//   rise_pulse  - one-cycle pulse on a 0->1 commit
//   fall_pulse  - one-cycle pulse on a 1->0 commit
//   busy        - timer currently owned by a channel
//   grant_id    - current or most recent owner index
// Optional (macro DEBOUNCE_ABORT_CNT_EN):
//   abort_clr   - synchronous clear of abort_count (wins over increment)
//   abort_count - saturating count of aborted stability counts
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic                     clk,
  input  logic                     async_reset,
  input  logic [N_CH-1:0]          in,
  output logic [N_CH-1:0]          out,
  output logic [N_CH-1:0]          rise_pulse,
  output logic [N_CH-1:0]          fall_pulse,
  output logic                     busy,
  output logic [clog2(N_CH)-1:0]   grant_id
`ifdef DEBOUNCE_ABORT_CNT_EN
  ,
  input  logic [0:0]               abort_clr,
  output logic [7:0]               abort_count
`endif
);

  localparam int                   IW   = clog2(N_CH);
  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [N_CH-1:0]      sync_p0;
  logic [N_CH-1:0]      sync_p1;
  logic [N_CH-1:0]      req;
  state_t               state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        pick;
  logic                 pick_vld;
  logic [CNT_WIDTH-1:0] timer;
  logic                 timer_load;
  logic                 timer_inc;
  logic                 owner_req;
  logic                 term_hit;

  // Stage p0 -> p1: two-flop synchroniser per channel
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  // A channel requests the timer for as long as its synchronised level
  // disagrees with what has been committed; nothing is latched.
  assign req       = sync_p1 ^ out;
  assign owner_req = req[owner];
  assign term_hit  = (timer == TERM);
  assign busy      = (state == COUNT);

  rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .valid      (pick_vld)
  );

  // Grant / commit control
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IW'(N_CH - 1);
      grant_id   <= '0;
      out        <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner      <= pick;
            last_grant <= pick;
            grant_id   <= pick;
            state      <= COUNT;
          end
        end
        COUNT: begin
          if (!owner_req) begin
            state <= IDLE;
          end else if (term_hit) begin
            out[owner] <= sync_p1[owner];
            if (sync_p1[owner]) rise_pulse[owner] <= 1'b1;
            else                fall_pulse[owner] <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero on every grant, abort and commit; otherwise advance while owned.
  always_comb begin
    timer_load = 1'b0;
    timer_inc  = 1'b0;
    case (state)
      IDLE:  timer_load = pick_vld;
      COUNT: begin
        if (!owner_req || term_hit) timer_load = 1'b1;
        else                        timer_inc  = 1'b1;
      end
      default: timer_load = 1'b1;
    endcase
  end

  // Shared stability timer (load has priority over increment)
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      timer <= '0;
    end else if (timer_load) begin
      timer <= '0;
    end else if (timer_inc) begin
      timer <= timer + 1'b1;
    end
  end

`ifdef DEBOUNCE_ABORT_CNT_EN
  logic abort_evt;
  assign abort_evt = (state == COUNT) && !owner_req;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      abort_count <= '0;
    end else if (abort_clr[0]) begin
      abort_count <= '0;
    end else if (abort_evt && (abort_count != 8'hFF)) begin
      abort_count <= abort_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N_CH raw board inputs with one shared stability timer instead of one timer per input.
- Per-channel synchronisers detect a mismatch between the synchronised input and the committed output. A round-robin arbiter grants the shared timer to one requesting channel at a time.
- The granted channel's output is committed after STABLE_CYCLES consecutive stable cycles.
- Sits between board pins (buttons, switches) and user logic. It replaces a per-input debouncer bank.

Parameters:
- N_CH, 4, number of input channels (2..16).
- CNT_WIDTH, 20, width of the shared timer.
- STABLE_CYCLES, 500000, required stable cycles: 10 ms at 50 MHz. Must be >= 2 and < 2**CNT_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- async_reset  in  1  asynchronous, active-high reset.
- in  in  N_CH  raw asynchronous inputs.
- out  out  N_CH  debounced, committed levels.
- rise_pulse  out  N_CH  one-cycle pulse when out[i] commits 0->1.
- fall_pulse  out  N_CH  one-cycle pulse when out[i] commits 1->0.
- busy  out  1  high while the timer is owned (state COUNT).
- grant_id  out  clog2(N_CH)  current or last owner channel index.

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is asynchronous and active-high.
  - Reset is asynchronous-assert. All flops clear immediately: sync stages, out, pulses, timer and busy = 0; state = IDLE; last_grant = N_CH-1; grant_id = 0.
  - Reset mid-COUNT abandons the count with no commit and no pulse.
- Synchronisers: each channel has a 2-flop synchroniser; sync[i] is the second stage.
- Request: req[i] = sync[i] XOR out[i], combinational. There are no stored request flags.
- FSM state IDLE:
  - If req is nonzero, pick the first set bit scanning from (last_grant+1) mod N_CH upward with wrap.
  - On that edge: owner <= pick, last_grant <= pick, grant_id <= pick, timer <= 0, state <= COUNT.
  - If req = 0, stay in IDLE.
- FSM state COUNT, evaluated each cycle:
  - Abort: if req[owner] = 0 (the input bounced back), go to IDLE with timer <= 0. No commit, no pulse.
  - Commit: else if timer == STABLE_CYCLES-1, then out[owner] <= sync[owner]. Pulse the matching rise_pulse or fall_pulse bit for exactly the next cycle. Go to IDLE, timer <= 0.
  - Otherwise, timer <= timer+1.
- Timer: load-to-zero has priority over increment. The timer never wraps, because it is bounded by the commit compare.
- Latency: in edge -> sync: 2 cycles; sync -> grant: 1 cycle (IDLE); grant -> commit: STABLE_CYCLES cycles. Uncontended total is STABLE_CYCLES+3 edges from the input change to the out change.
- Contention:
  - Waiting channels are not timed; timing starts only at grant.
  - A channel whose req drops while waiting is simply not picked.
  - After a commit or abort, the FSM spends 1 IDLE cycle before the next grant.
- Other channels: req toggling on a non-owner during COUNT has no effect on the current count.
- Pulses: at most one bit of rise_pulse|fall_pulse is high in any cycle. Pulses are registered.
- Fairness: a continuously requesting channel is granted within N_CH-1 other grants.

Optional Feature:
- Macro: DEBOUNCE_ABORT_CNT_EN.
- Defined:
  - Adds output abort_count [7:0], a saturating count of COUNT->IDLE aborts across all channels.
  - Adds input abort_clr [0:0], which synchronously zeroes the count; clear wins over a same-cycle increment.
  - abort_count resets to 0.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package debounce_pkg:
  - FSM state enum {IDLE, COUNT}.
  - Default constants DEFAULT_STABLE_CYCLES=500000 and DEFAULT_CNT_WIDTH=20.
  - Function for the index width clog2.
- Sub-module rr_arbiter (N parameter):
  - Inputs: req[N], last_grant.
  - Outputs: pick index and valid.
  - Purely combinational; instantiated once.
- Shared timer: the team's existing loadable register/counter (load priority over inc), WIDTH = CNT_WIDTH.

Test Plan (N_CH=4, STABLE_CYCLES=8):
- Reset then idle: hold async_reset 3 cycles, in=0000 -> out=0000, pulses=0, busy=0, grant_id=0 throughout.
- Clean press: in[1] 0->1 and held -> busy rises 3 cycles later, grant_id=1, out[1]=1 exactly 11 edges after the change, rise_pulse[1] high 1 cycle, busy=0 next.
- Bounce abort: in[2] high for 5 cycles after sync, then low -> no out change, no pulse, FSM back to IDLE, abort_count=1 when DEBOUNCE_ABORT_CNT_EN is defined.
- Contention and round-robin: in=1111 simultaneously -> grants in order 0,1,2,3. Each commits after 8 COUNT cycles plus 1 IDLE gap; out=1111 after 4 commits; four rise pulses, never overlapping.
- Release: from out[3]=1, drive in[3]=0 -> fall_pulse[3] one cycle, out[3]=0 after 11 edges.
- Reset mid-count: assert async_reset while COUNT timer=5 -> out, busy and timer immediately 0. After release with in still high, a fresh full 8-cycle count occurs before the commit.
